display_bcd_seq: RTL
====================

Name: display_bcd_seq

Overview:
- Sequential, parametrised successor to the combinational 3-digit binary-to-7-segment display path.
- Converts an unsigned LARGURA-bit value to DIGITOS BCD digits with an iterative shift-add-3 (double-dabble) engine, one bit per clock.
- Applies leading-zero blanking and overflow indication, then drives registered 7-segment outputs that hold until the next conversion completes.
- Sits between datapath counters/scores and the board HEX displays; start/busy/done handshake.

Parameters:
- LARGURA, 12, width of the binary input (1..20).
- DIGITOS, 4, number of BCD digits / 7-segment displays driven (1..6).
- APAGA_ZEROS, 1, 1 = blank leading zeros (digit 0 always shown); 0 = show all digits.
- ATIVO_BAIXO, 1, 1 = segment outputs active-low (segment lit = 0); 0 = active-high.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- entrada  input  LARGURA  unsigned value to display; sampled only on accepted start.
- iniciar  input  1  start request; accepted only when ocupado=0.
- ocupado  output  1  conversion in progress.
- pronto  output  1  one-cycle pulse when new digits are on the outputs.
- overflow  output  1  last accepted value exceeded 10^DIGITOS-1; held until next completion.
- digitos  output  7*DIGITOS  segments per digit, bit order gfedcba; digit 0 (least significant) in [6:0], digit i in [7i+6:7i].

Behaviour:
- Reset (async, immediate): ocupado=0, pronto=0, overflow=0, every digit blank (0x7F when ATIVO_BAIXO=1, 0x00 otherwise), FSM to OCIOSO. A conversion in progress is aborted; no pronto is issued.
- FSM states: OCIOSO, CONVERTE, ATUALIZA.
- OCIOSO:
  - iniciar=1 at edge k latches entrada into the shift register, clears the BCD accumulator (4*DIGITOS bits), loads bit counter = LARGURA, and sets ocupado=1.
  - Compare entrada > 10^DIGITOS-1 (constant computed at elaboration) and latch the result as ovf_int.
  - Go to CONVERTE.
- CONVERTE: each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by one and decrement the counter. After LARGURA cycles go to ATUALIZA.
- ATUALIZA (one cycle):
  - Register the segment patterns: overflow <= ovf_int; ocupado <= 0; pronto <= 1 for exactly one cycle; return to OCIOSO.
  - ovf_int=1: every digit shows a dash (segment g only: 0x3F active-low).
  - ovf_int=0: each nibble is decoded as 0-9.
  - With APAGA_ZEROS=1, every digit above the most-significant non-zero digit is blank, and digit 0 is never blanked. Zeros between non-zero digits are shown.
- Latency: accepted at edge k; digitos, overflow and pronto update at edge k+LARGURA+1; ocupado is high from k to k+LARGURA+1.
- iniciar while ocupado=1 is ignored (not queued). iniciar held high in OCIOSO right after pronto starts a new conversion the next edge.
- entrada changes during a conversion have no effect.
- Outputs are stable between completions; no glitches from the conversion engine reach digitos.
- Nibble codes 10-15 cannot occur; if decoded, they map to blank.
- Active-low segment codes (gfedcba): 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10. ATIVO_BAIXO=0 inverts all patterns.

Test Plan:
- Defaults, after reset -> digitos all 0x7F, ocupado=0, pronto=0, overflow=0. Then entrada=0, iniciar pulse -> pronto at edge 13 after accept; digit0=0x40, digits 1-3=0x7F.
- Defaults, entrada=4095 -> digit3=0x19, digit2=0x40, digit1=0x10, digit0=0x12, overflow=0; ocupado high for exactly 13 cycles.
- Defaults, entrada=105 -> digit3=0x7F, digit2=0x79, digit1=0x40 (inner zero shown), digit0=0x12. Repeat with APAGA_ZEROS=0 -> digit3=0x40.
- DIGITOS=3, entrada=1000 -> overflow=1, all three digits 0x3F. Then entrada=999 -> overflow=0, digits 0x10,0x10,0x10.
- Defaults, iniciar with 4095, then iniciar with 7 at cycle 5 of the conversion -> only one pronto; result shows 4095. Then iniciar with 7 -> digit0=0x78.
- Defaults, conversion of 1234 started, reset asserted at cycle 6 -> immediate blank outputs, ocupado=0, no pronto. After reset release, a new conversion of 1234 -> 0x79,0x24,0x30,0x19 (digit3..0).

Source files
------------

// File: rtl/display_bcd_seq.sv
// rtl/display_bcd_seq.sv - sequential double-dabble binary to 7-segment display driver
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   entrada   unsigned value, sampled on accepted start
//   iniciar   start request, accepted only while idle
//   ocupado   conversion in progress
//   pronto    one-cycle pulse when new digits are on the outputs
//   overflow  last value exceeded 10^DIGITOS-1, held until next completion
//   digitos   gfedcba segments per digit, digit 0 in [6:0]
module display_bcd_seq #(
    parameter int LARGURA     = 12,
    parameter int DIGITOS     = 4,
    parameter int APAGA_ZEROS = 1,
    parameter int ATIVO_BAIXO = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LARGURA-1:0]     entrada,
    input  logic                   iniciar,
    output logic                   ocupado,
    output logic                   pronto,
    output logic                   overflow,
    output logic [7*DIGITOS-1:0]   digitos
);

    localparam int BW = 4 * DIGITOS;
    localparam int CW = $clog2(LARGURA + 1);

    function automatic int max_val();
        int v;
        v = 1;
        for (int i = 0; i < DIGITOS; i++) v = v * 10;
        return v - 1;
    endfunction

    localparam logic [31:0] MAXV = 32'(max_val());

    // Segment patterns are built active-low and flipped once at the output.
    localparam logic [6:0] SEG_BLANK_AL = 7'h7F;
    localparam logic [6:0] SEG_DASH_AL  = 7'h3F;

    function automatic logic [6:0] dec_al(input logic [3:0] n);
        case (n)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK_AL;
        endcase
    endfunction

    function automatic logic [6:0] pol(input logic [6:0] al);
        return (ATIVO_BAIXO != 0) ? al : ~al;
    endfunction

    typedef enum logic [1:0] {OCIOSO, CONVERTE, ATUALIZA} estado_t;

    estado_t                estado_q, estado_d;
    logic [LARGURA-1:0]     bin_q, bin_d;
    logic [BW-1:0]          bcd_q, bcd_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   ovf_int_q, ovf_int_d;
    logic                   ocupado_q, ocupado_d;
    logic                   pronto_q, pronto_d;
    logic                   overflow_q, overflow_d;
    logic [7*DIGITOS-1:0]   digitos_q, digitos_d;

    logic [BW-1:0]          adj;
    logic [BW+LARGURA-1:0]  shifted;
    logic [7*DIGITOS-1:0]   segs;
    logic                   lead;
    logic [3:0]             nib;
    logic [6:0]             seg;
    logic [31:0]            ent_ext;

    always_comb begin
        estado_d   = estado_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ovf_int_d  = ovf_int_q;
        ocupado_d  = ocupado_q;
        pronto_d   = 1'b0;
        overflow_d = overflow_q;
        digitos_d  = digitos_q;
        ent_ext    = 32'(entrada);

        // Add-3 correction on every nibble >= 5, then one-bit shift of {bcd, bin}.
        adj = bcd_q;
        for (int i = 0; i < DIGITOS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        shifted = {adj, bin_q} << 1;

        // Walk from the top digit down; 'lead' stays set while only zeros were seen.
        segs = '0;
        lead = 1'b1;
        nib  = 4'd0;
        seg  = SEG_BLANK_AL;
        for (int i = DIGITOS - 1; i >= 0; i--) begin
            nib = bcd_q[4*i +: 4];
            if (ovf_int_q)
                seg = SEG_DASH_AL;
            else if ((APAGA_ZEROS != 0) && lead && (nib == 4'd0) && (i != 0))
                seg = SEG_BLANK_AL;
            else
                seg = dec_al(nib);
            if (nib != 4'd0) lead = 1'b0;
            segs[7*i +: 7] = pol(seg);
        end

        case (estado_q)
            OCIOSO: begin
                if (iniciar) begin
                    bin_d     = entrada;
                    bcd_d     = '0;
                    cnt_d     = CW'(LARGURA);
                    ovf_int_d = (ent_ext > MAXV);
                    ocupado_d = 1'b1;
                    estado_d  = CONVERTE;
                end
            end
            CONVERTE: begin
                bcd_d = shifted[BW+LARGURA-1:LARGURA];
                bin_d = shifted[LARGURA-1:0];
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) estado_d = ATUALIZA;
            end
            ATUALIZA: begin
                digitos_d  = segs;
                overflow_d = ovf_int_q;
                ocupado_d  = 1'b0;
                pronto_d   = 1'b1;
                estado_d   = OCIOSO;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ovf_int_q  <= 1'b0;
            ocupado_q  <= 1'b0;
            pronto_q   <= 1'b0;
            overflow_q <= 1'b0;
            digitos_q  <= {DIGITOS{pol(SEG_BLANK_AL)}};
        end else begin
            estado_q   <= estado_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ovf_int_q  <= ovf_int_d;
            ocupado_q  <= ocupado_d;
            pronto_q   <= pronto_d;
            overflow_q <= overflow_d;
            digitos_q  <= digitos_d;
        end
    end

    assign ocupado  = ocupado_q;
    assign pronto   = pronto_q;
    assign overflow = overflow_q;
    assign digitos  = digitos_q;

endmodule
